// File: rtl/box_downscaler_if.sv
// Bus bundle for box_downscaler: start/status, source ROM read port and framebuffer write port.
// master = downscaler side, slave = ROM/framebuffer/controller side.
interface box_downscaler_if;
    logic        start;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic [18:0] ram_wraddr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic        busy;
    logic        done;

    modport master (
        input  start, rom_data,
        output rom_addr, ram_wraddr, ram_data, ram_wren, busy, done
    );

    modport slave (
        output start, rom_data,
        input  rom_addr, ram_wraddr, ram_data, ram_wren, busy, done
    );
endinterface

// File: rtl/box_downscaler.sv
// 2x2 box-average downscaler: reads a 1-cycle-latency source ROM, writes a half-size framebuffer.
// Optional macro BOX_AVG_RGB332_EN averages the R/G/B fields of RGB332 pixels separately.
module box_downscaler #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic             clk,
    input  logic             reset,
    box_downscaler_if.master bus
);
    localparam int AW = 19;
    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
`ifdef BOX_AVG_RGB332_EN
    localparam int ACC_W = 14;  // {R sum[4:0], G sum[4:0], B sum[3:0]}
`else
    localparam int ACC_W = 10;
`endif

    typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, WR, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_ox;
    logic [AW-1:0]    r_oy;
    logic [AW-1:0]    r_src_base;
    logic [AW-1:0]    r_dst_addr;
    logic [ACC_W-1:0] r_acc;
    logic [AW-1:0]    r_wraddr;
    logic [7:0]       r_wdata;
    logic             r_wren;
    logic             r_busy;
    logic             r_done;
    logic [AW-1:0]    w_rom_off;
    logic [AW-1:0]    w_rom_addr;
    logic             w_last_col;
    logic             w_last_px;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                                 input logic [7:0] px);
`ifdef BOX_AVG_RGB332_EN
        acc_add = {acc[13:9] + {2'b00, px[7:5]},
                   acc[8:4]  + {2'b00, px[4:2]},
                   acc[3:0]  + {2'b00, px[1:0]}};
`else
        acc_add = acc + ACC_W'(px);
`endif
    endfunction

    // Truncating divide by four of each accumulated field.
    function automatic logic [7:0] acc_avg(input logic [ACC_W-1:0] acc);
`ifdef BOX_AVG_RGB332_EN
        acc_avg = {3'(acc[13:9] >> 2), 3'(acc[8:4] >> 2), 2'(acc[3:0] >> 2)};
`else
        acc_avg = 8'(acc >> 2);
`endif
    endfunction

    assign w_last_col = (r_ox == AW'(OW - 1));
    assign w_last_px  = w_last_col && (r_oy == AW'(OH - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: if (bus.start) w_next = P0;
            P0:         w_next = P1;
            P1:         w_next = P2;
            P2:         w_next = P3;
            P3:         w_next = WR;
            WR:         w_next = w_last_px ? DONE : P0;
            default:    w_next = IDLE;
        endcase
    end

    // ROM address is combinational so data for the tap issued in Pn arrives in Pn+1.
    always_comb begin
        w_rom_off = '0;
        case (r_state)
            P1:      w_rom_off = AW'(1);
            P2:      w_rom_off = AW'(IMG_W);
            P3:      w_rom_off = AW'(IMG_W + 1);
            default: w_rom_off = '0;
        endcase
        w_rom_addr = r_src_base + w_rom_off;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ox       <= '0;
            r_oy       <= '0;
            r_src_base <= '0;
            r_dst_addr <= '0;
            r_acc      <= '0;
            r_wraddr   <= '0;
            r_wdata    <= '0;
            r_wren     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            r_busy <= (w_next != IDLE && w_next != DONE) || (r_state == WR);
            r_done <= (r_state == DONE) && (w_next == DONE);
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_ox       <= '0;
                        r_oy       <= '0;
                        r_src_base <= '0;
                        r_dst_addr <= '0;
                    end
                end
                P1:     r_acc <= acc_add('0, bus.rom_data);
                P2, P3: r_acc <= acc_add(r_acc, bus.rom_data);
                WR: begin
                    r_wren   <= 1'b1;
                    r_wraddr <= r_dst_addr;
                    r_wdata  <= acc_avg(acc_add(r_acc, bus.rom_data));
                    if (w_last_px) begin
                        r_ox       <= '0;
                        r_oy       <= '0;
                        r_src_base <= '0;
                        r_dst_addr <= '0;
                    end else begin
                        r_dst_addr <= r_dst_addr + AW'(1);
                        // Row wrap: base moves from the last pair of this row pair to the next row pair.
                        if (w_last_col) begin
                            r_ox       <= '0;
                            r_oy       <= r_oy + AW'(1);
                            r_src_base <= r_src_base + AW'(IMG_W + 2);
                        end else begin
                            r_ox       <= r_ox + AW'(1);
                            r_src_base <= r_src_base + AW'(2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr   = w_rom_addr;
    assign bus.ram_wraddr = r_wraddr;
    assign bus.ram_data   = r_wdata;
    assign bus.ram_wren   = r_wren;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_box_downscaler.sv
// Scoreboard bench for box_downscaler: stimulus pushes expected framebuffer writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_box_downscaler;
    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int NPIX  = (IMG_W / 2) * (IMG_H / 2);
    localparam int DONE_IDX = 5 * NPIX + 1;
`ifdef BOX_AVG_RGB332_EN
    localparam logic [7:0] EXP32 = 8'h11;
    localparam logic [7:0] EXP33 = 8'h20;
`else
    localparam logic [7:0] EXP32 = 8'd25;
    localparam logic [7:0] EXP33 = 8'h38;
`endif

    logic clk = 1'b0;
    logic reset;
    box_downscaler_if bus ();

    box_downscaler #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [0:IMG_W*IMG_H-1];
    logic [26:0] exp_q [$];
    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr[14:0]];

    always @(negedge clk) begin
        if (bus.ram_wren === 1'b1) begin
            logic [26:0] e;
            n_wr++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                         bus.ram_wraddr, bus.ram_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.ram_wraddr, bus.ram_data} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             bus.ram_wraddr, bus.ram_data, e[26:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < IMG_W * IMG_H; i++) rom[i] = v;
    endtask

    task automatic push_pass(input logic [7:0] first, input logic [7:0] rest);
        for (int i = 0; i < NPIX; i++) exp_q.push_back({19'(i), (i == 0) ? first : rest});
    endtask

    // idx counts negedges after the edge that samples start; idx 0 is the P0 cycle.
    task automatic run_pass(input string tag, input int abort_wr, input bit mid_start);
        int idx;
        int wr0;
        int ra [9] = '{0, 1, IMG_W, IMG_W + 1, 0, 2, 3, IMG_W + 2, IMG_W + 3};
        wr0 = n_wr;
        bus.start = 1'b1;
        @(negedge clk);
        idx = 0;
        chk({tag, "_busy_after_start"}, 32'(bus.busy), 1);
        chk({tag, "_done_after_start"}, 32'(bus.done), 0);
        while (bus.done !== 1'b1 && idx < 30000) begin
            if (idx < 9 && idx != 4) chk({tag, "_rom_addr"}, 32'(bus.rom_addr), ra[idx]);
            bus.start = mid_start && (idx == 100);
            if (abort_wr > 0 && idx == 5 * abort_wr) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk({tag, "_abort_wren"}, 32'(bus.ram_wren), 0);
                chk({tag, "_abort_busy"}, 32'(bus.busy), 0);
                chk({tag, "_abort_done"}, 32'(bus.done), 0);
                chk({tag, "_abort_writes"}, n_wr - wr0, abort_wr);
                exp_q.delete();
                return;
            end
            @(negedge clk);
            idx++;
        end
        bus.start = 1'b0;
        chk({tag, "_done_cycle"}, idx, DONE_IDX);
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
        chk({tag, "_write_count"}, n_wr - wr0, NPIX);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        fill_rom(8'h00);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_wren", 32'(bus.ram_wren), 0);
        chk("rst_wraddr", 32'(bus.ram_wraddr), 0);
        chk("rst_data", 32'(bus.ram_data), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);

        // Flat mid-grey image, with a stray start pulse mid-pass.
        fill_rom(8'h80);
        push_pass(8'h80, 8'h80);
        run_pass("flat", 0, 1'b1);
        chk("flat_done_hold", 32'(bus.done), 1);

        // Restart from DONE with a single non-trivial 2x2 block.
        fill_rom(8'h00);
        rom[0] = 8'd10;
        rom[1] = 8'd20;
        rom[IMG_W] = 8'd30;
        rom[IMG_W + 1] = 8'd41;
        push_pass(EXP32, 8'h00);
        run_pass("block", 0, 1'b0);

        // Colour-field pixel, aborted by reset after 1000 writes.
        fill_rom(8'h00);
        rom[0] = 8'hE0;
        push_pass(EXP33, 8'h00);
        run_pass("abort", 1000, 1'b0);
        repeat (20) @(negedge clk);
        chk("post_abort_busy", 32'(bus.busy), 0);
        chk("post_abort_done", 32'(bus.done), 0);

        // Fresh start after the abort must begin again at address 0.
        push_pass(EXP33, 8'h00);
        run_pass("restart", 50, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
